mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single slow memory port.
// Instruction (i_*) and data (d_*) sides each present a held read/write request
// and see a one-cycle ready strobe on completion. Conflicts in IDLE are resolved
// round-robin. Every transaction is followed by one TURN cycle and one IDLE cycle.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_read/i_write/i_addr/i_wdata/i_rdata/i_ready   instruction-side request port
//   d_read/d_write/d_addr/d_wdata/d_rdata/d_ready   data-side request port
//   mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready   shared memory port
//   i_count, d_count            saturating completed-transaction counters
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  i_count,
  output logic [CNT_W-1:0]  d_count
);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StTurn} state_e;

  state_e             state_q, state_d;
  logic               last_d_q, last_d_d;  // 1: data side was granted most recently
  logic [CNT_W-1:0]   i_count_q, i_count_d;
  logic [CNT_W-1:0]   d_count_q, d_count_d;

  logic i_pend, d_pend;
  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;

  // Read data is broadcast; only the side whose ready is high consumes it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign i_count = i_count_q;
  assign d_count = d_count_q;

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    i_count_d = i_count_q;
    d_count_d = d_count_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_pend && d_pend) begin
          // Round-robin: hand the grant to whoever did not get it last time.
          if (last_d_q) begin
            state_d  = StGrantI;
            last_d_d = 1'b0;
          end else begin
            state_d  = StGrantD;
            last_d_d = 1'b1;
          end
        end else if (i_pend) begin
          state_d  = StGrantI;
          last_d_d = 1'b0;
        end else if (d_pend) begin
          state_d  = StGrantD;
          last_d_d = 1'b1;
        end
      end

      StGrantI: begin
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        mem_write = i_write;
        mem_read  = i_read & ~i_write;  // write wins when both are raised
        i_ready   = mem_ready;
        if (mem_ready) begin
          state_d = StTurn;
          if (i_count_q != '1) i_count_d = i_count_q + CNT_W'(1);
        end
      end

      StGrantD: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        d_ready   = mem_ready;
        if (mem_ready) begin
          state_d = StTurn;
          if (d_count_q != '1) d_count_d = d_count_q + CNT_W'(1);
        end
      end

      StTurn: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_d_q  <= 1'b0;
      i_count_q <= '0;
      d_count_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      i_count_q <= i_count_d;
      d_count_q <= d_count_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes the expected transaction
// (side, command, address, data, post-completion count) into a queue; a monitor
// pops and compares each time a ready strobe appears.
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read, i_write, d_read, d_write;
  logic [27:0]  i_addr, d_addr;
  logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata;
  logic         i_ready, d_ready;
  logic         mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [15:0]  i_count, d_count;

  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .i_count   (i_count),
    .d_count   (d_count)
  );

  typedef struct {
    bit           side_d;
    bit           wr;
    bit           rd;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic [15:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mem_lat  = 2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_txn(input bit side_d, input bit wr, input bit rd, input logic [27:0] addr,
                            input logic [127:0] wdata, input logic [127:0] rdata,
                            input logic [15:0] cnt);
    exp_t e;
    e.side_d = side_d; e.wr = wr; e.rd = rd; e.addr = addr;
    e.wdata = wdata; e.rdata = rdata; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Raise a request, hold it until its ready strobe, then return just after that edge.
  task automatic run_req(input bit side_d, input bit rd, input bit wr, input logic [27:0] addr,
                         input logic [127:0] wd, input bit drop);
    bit done = 1'b0;
    if (side_d) begin
      d_read = rd; d_write = wr; d_addr = addr; d_wdata = wd;
    end else begin
      i_read = rd; i_write = wr; i_addr = addr; i_wdata = wd;
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (side_d ? d_ready : i_ready) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL req_timeout: side %0d addr %h got no ready within 200 cycles", side_d, addr);
    end
    @(posedge clk);
    #1;
    if (drop) begin
      if (side_d) begin d_read = 1'b0; d_write = 1'b0; end
      else begin i_read = 1'b0; i_write = 1'b0; end
    end
  endtask

  // Slow memory: ready after mem_lat active cycles, one cycle wide.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
      end else if (mem_read || mem_write) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = (mem_addr == 28'h0000010) ? {16{8'hA5}} : {4{mem_addr, 4'hC}};
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: compares every completion against the scoreboard head.
  initial begin
    exp_t e;
    bit   cnt_pend = 1'b0;
    bit   cnt_side = 1'b0;
    logic [15:0] cnt_exp = '0;
    bit   prev_active = 1'b0;
    bit   have_last = 1'b0;
    int   cyc = 0;
    int   last_ready_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cnt_pend) begin
        check(cnt_side ? "d_count" : "i_count", cnt_side ? d_count : i_count, cnt_exp);
        check("turn_mem_idle", {mem_read, mem_write}, 2'b00);
        cnt_pend = 1'b0;
      end
      if ((mem_read || mem_write) && !prev_active && have_last)
        check("txn_gap", (cyc - last_ready_cyc) >= 3, 1'b1);
      prev_active = mem_read || mem_write;
      if (i_ready || d_ready) begin
        check("ready_excl", i_ready && d_ready, 1'b0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL sb_empty: ready seen (i %0d d %0d) with nothing expected", i_ready, d_ready);
        end else begin
          e = sb.pop_front();
          check("grant_side", d_ready, e.side_d);
          check("mem_write", mem_write, e.wr);
          check("mem_read", mem_read, e.rd);
          check("mem_addr", mem_addr, e.addr);
          if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
          if (e.rd) check("rdata", e.side_d ? d_rdata : i_rdata, e.rdata);
          cnt_pend = 1'b1;
          cnt_side = e.side_d;
          cnt_exp  = e.cnt;
        end
        last_ready_cyc = cyc;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    rst = 1'b1;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_rw", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_mem_wdata", mem_wdata, 128'h0);
    check("rst_readys", {i_ready, d_ready}, 2'b00);
    check("rst_counts", {i_count, d_count}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single instruction read, minimum latency
    expect_txn(0, 0, 1, 28'h0000010, '0, {16{8'hA5}}, 16'd1);
    fork
      run_req(0, 1, 0, 28'h0000010, '0, 1);
      begin
        @(negedge clk);
        check("lat_idle", mem_read, 1'b0);
        @(negedge clk);
        check("lat_grant", {mem_read, mem_addr}, {1'b1, 28'h0000010});
      end
    join
    repeat (3) @(posedge clk);

    // Simultaneous I read and D write right after reset: D first
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expect_txn(1, 1, 0, 28'h0000100, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, '0, 16'd1);
    expect_txn(0, 0, 1, 28'h0000200, '0, 128'h0000200C_0000200C_0000200C_0000200C, 16'd1);
    fork
      run_req(1, 0, 1, 28'h0000100, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 1);
      run_req(0, 1, 0, 28'h0000200, '0, 1);
    join
    repeat (3) @(posedge clk);
    #1;

    // Continuous contention: D,I,D,I,D,I
    expect_txn(1, 0, 1, 28'h0000300, '0, 128'h0000300C_0000300C_0000300C_0000300C, 16'd2);
    expect_txn(0, 1, 0, 28'h0000400, {4{32'h1111_1111}}, '0, 16'd2);
    expect_txn(1, 0, 1, 28'h0000301, '0, 128'h0000301C_0000301C_0000301C_0000301C, 16'd3);
    expect_txn(0, 1, 0, 28'h0000401, {4{32'h2222_2222}}, '0, 16'd3);
    expect_txn(1, 0, 1, 28'h0000302, '0, 128'h0000302C_0000302C_0000302C_0000302C, 16'd4);
    expect_txn(0, 1, 0, 28'h0000402, {4{32'h3333_3333}}, '0, 16'd4);
    fork
      begin
        run_req(1, 1, 0, 28'h0000300, '0, 0);
        run_req(1, 1, 0, 28'h0000301, '0, 0);
        run_req(1, 1, 0, 28'h0000302, '0, 1);
      end
      begin
        run_req(0, 0, 1, 28'h0000400, {4{32'h1111_1111}}, 0);
        run_req(0, 0, 1, 28'h0000401, {4{32'h2222_2222}}, 0);
        run_req(0, 0, 1, 28'h0000402, {4{32'h3333_3333}}, 1);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Read and write together: write wins for the whole grant
    expect_txn(1, 1, 0, 28'h0000020, {4{32'hCAFE_F00D}}, '0, 16'd5);
    fork
      run_req(1, 1, 1, 28'h0000020, {4{32'hCAFE_F00D}}, 1);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (mem_read || mem_write) check("write_wins", {mem_write, mem_read}, 2'b10);
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Requester withdraws mid-grant: memory command follows it low, grant held
    mem_lat = 4;
    d_read = 1'b1; d_addr = 28'h0000030;
    @(negedge clk);
    @(negedge clk);
    check("drop_pre", mem_read, 1'b1);
    @(posedge clk);
    #1 d_read = 1'b0;
    @(negedge clk);
    check("drop_follow", {mem_read, mem_write}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("drop_hold", {mem_read, d_ready, i_ready}, 3'b000);
    @(posedge clk);
    #1;
    expect_txn(1, 0, 1, 28'h0000030, '0, 128'h0000030C_0000030C_0000030C_0000030C, 16'd6);
    fork
      run_req(1, 1, 0, 28'h0000030, '0, 1);
      begin
        @(negedge clk);
        check("regrant_same", mem_read, 1'b1);
      end
    join
    mem_lat = 2;
    repeat (3) @(posedge clk);
    #1;

    // Reset during an in-flight D grant
    mem_lat = 1000;
    d_write = 1'b1; d_addr = 28'h0000040; d_wdata = {4{32'h5555_AAAA}};
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_grant", {mem_write, mem_addr}, {1'b1, 28'h0000040});
    @(posedge clk);
    #1 i_read = 1'b1; i_addr = 28'h0000050;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_rw", {mem_read, mem_write}, 2'b00);
    check("async_rst_addr", mem_addr, 28'h0);
    check("async_rst_wdata", mem_wdata, 128'h0);
    check("async_rst_ready", {i_ready, d_ready}, 2'b00);
    check("async_rst_cnt", {i_count, d_count}, 32'h0);
    d_write = 1'b0;
    mem_lat = 2;
    @(posedge clk);
    #1 rst = 1'b0;
    expect_txn(0, 0, 1, 28'h0000050, '0, 128'h0000050C_0000050C_0000050C_0000050C, 16'd1);
    fork
      run_req(0, 1, 0, 28'h0000050, '0, 1);
      begin
        @(negedge clk);
        check("post_rst_idle", mem_read, 1'b0);
        @(negedge clk);
        check("post_rst_grant", {mem_read, mem_addr}, {1'b1, 28'h0000050});
      end
    join
    repeat (3) @(posedge clk);

    // Counter saturation
    @(negedge clk);
    force dut.d_count_q = 16'hFFFE;
    #1 release dut.d_count_q;
    @(posedge clk);
    #1;
    expect_txn(1, 1, 0, 28'h0000060, {4{32'h0000_0001}}, '0, 16'hFFFF);
    expect_txn(1, 1, 0, 28'h0000061, {4{32'h0000_0002}}, '0, 16'hFFFF);
    run_req(1, 0, 1, 28'h0000060, {4{32'h0000_0001}}, 1);
    run_req(1, 0, 1, 28'h0000061, {4{32'h0000_0002}}, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
